// File: rtl/alu_issue_sched.sv
// In-order issue scheduler for the single-issue ALU/jump datapath: a fetch FIFO
// feeding a registered execute slot, with load scoreboard, hazard stalls and jump flush.
module alu_issue_sched #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_vld,
  input  logic [XLEN-1:0] fetch_instr,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            fetch_rdy,
  output logic [XLEN-1:0] issue_instr,
  output logic [XLEN-1:0] issue_pc,
  output logic            issue_vld,
  input  logic            jump_vld,
  input  logic            mem_rdy,
  input  logic            membuf_empty,
  input  logic            ld_wb_vld,
  input  logic [4:0]      ld_wb_sel
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [XLEN-1:0]  instr_mem [DEPTH];
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      sb;

  logic [XLEN-1:0]  instr_p1, pc_p1;
  logic             vld_p1;

  logic [XLEN-1:0]  head_instr_p0, head_pc_p0;
  logic [4:0]       op_p0, rs0_p0, rs1_p0, rd_p0;
  logic             use_rs0_p0, use_rs1_p0, use_rd_p0;
  logic             is_load_p0, is_mem_p0, is_sys_p0;
  logic             slot_is_load;
  logic [4:0]       slot_rd;
  logic             stall_p0, push, pop;
  logic [31:0]      sb_set, sb_clr;

  // A register is busy if a load owns it, either pending writeback or still in the slot.
  function automatic logic busy(input logic [4:0] r, input logic [31:0] sbv,
                                input logic sl_load, input logic [4:0] sl_rd);
    return (r != 5'd0) && (sbv[r] || (sl_load && (sl_rd == r)));
  endfunction

  // Stage p0: FIFO head decode and hazard check
  assign head_instr_p0 = instr_mem[rd_ptr];
  assign head_pc_p0    = pc_mem[rd_ptr];
  assign op_p0  = head_instr_p0[6:2];
  assign rs0_p0 = head_instr_p0[19:15];
  assign rs1_p0 = head_instr_p0[24:20];
  assign rd_p0  = head_instr_p0[11:7];

  always_comb begin
    use_rs0_p0 = 1'b0;
    use_rs1_p0 = 1'b0;
    use_rd_p0  = 1'b0;
    is_load_p0 = 1'b0;
    is_mem_p0  = 1'b0;
    is_sys_p0  = 1'b0;
    if (head_instr_p0[1:0] == 2'b11) begin
      case (op_p0)
        OP_LUI, OP_AUIPC, OP_JAL: use_rd_p0 = 1'b1;
        OP_JALR: begin
          use_rs0_p0 = 1'b1;
          use_rd_p0  = 1'b1;
        end
        OP_BRANCH: begin
          use_rs0_p0 = 1'b1;
          use_rs1_p0 = 1'b1;
        end
        OP_LOAD: begin
          use_rs0_p0 = 1'b1;
          is_load_p0 = 1'b1;
          is_mem_p0  = 1'b1;
        end
        OP_STORE: begin
          use_rs0_p0 = 1'b1;
          use_rs1_p0 = 1'b1;
          is_mem_p0  = 1'b1;
        end
        OP_IMM: begin
          use_rs0_p0 = 1'b1;
          use_rd_p0  = 1'b1;
        end
        OP_OP: begin
          use_rs0_p0 = 1'b1;
          use_rs1_p0 = 1'b1;
          use_rd_p0  = 1'b1;
        end
        OP_SYSTEM: begin
          use_rs0_p0 = ~head_instr_p0[14];
          use_rd_p0  = 1'b1;
          is_sys_p0  = 1'b1;
        end
        default: is_sys_p0 = 1'b1;
      endcase
    end
  end

  assign slot_is_load = vld_p1 && (instr_p1[1:0] == 2'b11) && (instr_p1[6:2] == OP_LOAD);
  assign slot_rd      = instr_p1[11:7];

  assign stall_p0 = (use_rs0_p0 && busy(rs0_p0, sb, slot_is_load, slot_rd))
                 || (use_rs1_p0 && busy(rs1_p0, sb, slot_is_load, slot_rd))
                 || (use_rd_p0  && busy(rd_p0,  sb, slot_is_load, slot_rd))
                 || (is_mem_p0 && !mem_rdy)
                 || (is_sys_p0 && (!membuf_empty || (sb != 32'd0) || slot_is_load));

  // No same-cycle pop bypass: a full FIFO refuses even while it drains.
  assign fetch_rdy = (count != FULL);
  assign push      = fetch_vld && fetch_rdy && !jump_vld;
  assign pop       = (count != '0) && !stall_p0 && !jump_vld;

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= fetch_instr;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (jump_vld) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Stage p1: execute slot, one cycle per instruction, zeroed when empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else begin
      vld_p1   <= pop;
      instr_p1 <= pop ? head_instr_p0 : '0;
      pc_p1    <= pop ? head_pc_p0 : '0;
    end
  end

  assign issue_vld   = vld_p1;
  assign issue_instr = instr_p1;
  assign issue_pc    = pc_p1;

  // Loads always commit, so the slot load sets its bit; set wins over writeback clear.
  assign sb_set = (slot_is_load && (slot_rd != 5'd0)) ? (32'd1 << slot_rd) : 32'd0;
  assign sb_clr = ld_wb_vld ? (32'd1 << ld_wb_sel) : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb <= 32'd0;
    else      sb <= (sb & ~sb_clr) | sb_set;
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched: accepted fetches are queued and matched
// against issued instructions, plus directed timing checks for each hazard.
module tb_alu_issue_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_vld;
  logic [31:0] fetch_instr, fetch_pc;
  logic        fetch_rdy;
  logic [31:0] issue_instr, issue_pc;
  logic        issue_vld;
  logic        jump_vld, mem_rdy, membuf_empty, ld_wb_vld;
  logic [4:0]  ld_wb_sel;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_instr[$];
  logic [31:0] exp_pc[$];

  alu_issue_sched #(.XLEN(32), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .fetch_vld(fetch_vld), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_rdy(fetch_rdy),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .issue_vld(issue_vld),
    .jump_vld(jump_vld), .mem_rdy(mem_rdy), .membuf_empty(membuf_empty),
    .ld_wb_vld(ld_wb_vld), .ld_wb_sel(ld_wb_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
    return (32'(imm) << 20) | (32'(rs) << 15) | (32'(rd) << 7) | 32'h13;
  endfunction
  function automatic logic [31:0] lw(input int rd, input int rs);
    return (32'(rs) << 15) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
  endfunction
  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int rs1);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | 32'h23;
  endfunction
  function automatic logic [31:0] beq(input int rs1, input int rs2);
    return (32'(rs2) << 20) | (32'(rs1) << 15) | 32'h63;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p);
    fetch_vld   = v;
    fetch_instr = i;
    fetch_pc    = p;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'd0, 32'd0);
    repeat (n) step();
  endtask

  // Scoreboard: push on accepted fetch, pop on issue, drop younger work on flush or reset.
  always @(negedge clk) begin
    logic [31:0] ei, ep;
    if (!rst) begin
      exp_instr.delete();
      exp_pc.delete();
    end else begin
      if (issue_vld) begin
        if (exp_instr.size() == 0) begin
          chk("issue_unexpected", exp_instr.size(), 1);
        end else begin
          ei = exp_instr.pop_front();
          ep = exp_pc.pop_front();
          chk("issue_instr", issue_instr, ei);
          chk("issue_pc", issue_pc, ep);
        end
      end else begin
        chk("bubble_instr", issue_instr, 32'd0);
        chk("bubble_pc", issue_pc, 32'd0);
      end
      if (jump_vld) begin
        exp_instr.delete();
        exp_pc.delete();
      end else if (fetch_vld && fetch_rdy) begin
        exp_instr.push_back(fetch_instr);
        exp_pc.push_back(fetch_pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t3i[5];
    logic [31:0] t3p[5];
    rst = 1'b0;
    jump_vld = 1'b0; mem_rdy = 1'b1; membuf_empty = 1'b1;
    ld_wb_vld = 1'b0; ld_wb_sel = 5'd0;
    drive(1'b0, 32'd0, 32'd0);
    repeat (2) step();
    chk("rst_vld", issue_vld, 0);
    chk("rst_rdy", fetch_rdy, 1);
    chk("rst_instr", issue_instr, 0);
    chk("rst_pc", issue_pc, 0);
    rst = 1'b1;
    step();

    // back-to-back ADDI stream
    drive(1'b1, addi(1, 0, 1), 32'h100); step();
    chk("t1_rdy0", fetch_rdy, 1); chk("t1_lat0", issue_vld, 0);
    drive(1'b1, addi(2, 0, 2), 32'h104); step();
    chk("t1_rdy1", fetch_rdy, 1); chk("t1_lat1", issue_vld, 1);
    drive(1'b1, addi(3, 0, 3), 32'h108); step();
    chk("t1_rdy2", fetch_rdy, 1); chk("t1_tp2", issue_vld, 1);
    drive(1'b1, addi(4, 0, 4), 32'h10c); step();
    chk("t1_tp3", issue_vld, 1);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t1_tp4", issue_vld, 1);
    step();
    chk("t1_end", issue_vld, 0);

    // load-use stall
    idle(2);
    drive(1'b1, lw(5, 0), 32'h200); step();
    drive(1'b1, add(6, 5, 1), 32'h204); step();
    chk("t2_lw", issue_vld, 1);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t2_stall0", issue_vld, 0);
    step(); step();
    chk("t2_stall1", issue_vld, 0);
    ld_wb_vld = 1'b1; ld_wb_sel = 5'd5; step();
    ld_wb_vld = 1'b0;
    chk("t2_wb_edge", issue_vld, 0);
    step();
    chk("t2_issue", issue_vld, 1);

    // full FIFO behind a stalled store, pointer wrap
    idle(2);
    t3i[0] = sw(1, 2);       t3p[0] = 32'h300;
    t3i[1] = addi(10, 0, 1); t3p[1] = 32'h304;
    t3i[2] = addi(11, 0, 2); t3p[2] = 32'h308;
    t3i[3] = addi(12, 0, 3); t3p[3] = 32'h30c;
    t3i[4] = addi(13, 0, 4); t3p[4] = 32'h310;
    mem_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, t3i[k], t3p[k]);
      chk("t3_rdy", fetch_rdy, 1);
      step();
    end
    chk("t3_full", fetch_rdy, 0);
    chk("t3_hold", issue_vld, 0);
    drive(1'b1, t3i[4], t3p[4]); step();
    chk("t3_full2", fetch_rdy, 0);
    mem_rdy = 1'b1;
    chk("t3_nobypass", fetch_rdy, 0);
    step();
    chk("t3_sw_issue", issue_vld, 1);
    chk("t3_rdy_after_pop", fetch_rdy, 1);
    step();
    drive(1'b0, 32'd0, 32'd0);
    chk("t3_tp", issue_vld, 1);
    idle(6);

    // jump flush with queued work and a same-cycle fetch
    drive(1'b1, lw(9, 0), 32'h400); step();
    drive(1'b1, beq(9, 0), 32'h404); step();
    drive(1'b1, addi(14, 0, 1), 32'h408); step();
    drive(1'b1, addi(15, 0, 2), 32'h40c); step();
    drive(1'b1, addi(16, 0, 3), 32'h410); step();
    chk("t4_full", fetch_rdy, 0);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t4_stall", issue_vld, 0);
    ld_wb_vld = 1'b1; ld_wb_sel = 5'd9; step();
    ld_wb_vld = 1'b0;
    chk("t4_wb_edge", issue_vld, 0);
    step();
    chk("t4_beq", issue_vld, 1);
    chk("t4_rdy3", fetch_rdy, 1);
    jump_vld = 1'b1;
    drive(1'b1, addi(17, 0, 4), 32'h414); step();
    jump_vld = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("t4_flush_vld", issue_vld, 0);
    chk("t4_flush_rdy", fetch_rdy, 1);
    step();
    chk("t4_empty1", issue_vld, 0);
    step();
    chk("t4_empty2", issue_vld, 0);
    drive(1'b1, addi(18, 0, 5), 32'h418); step();
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t4_after", issue_vld, 1);

    // store held by membuf back-pressure
    idle(2);
    mem_rdy = 1'b0;
    drive(1'b1, sw(3, 4), 32'h500); step();
    drive(1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold", issue_vld, 0);
    end
    mem_rdy = 1'b1; step();
    chk("t5_issue", issue_vld, 1);

    // ECALL serialized behind a load and a busy membuf
    idle(2);
    membuf_empty = 1'b0;
    drive(1'b1, lw(7, 0), 32'h600); step();
    drive(1'b1, 32'h00000073, 32'h604); step();
    chk("t6_lw", issue_vld, 1);
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t6_hold0", issue_vld, 0);
    step();
    chk("t6_hold1", issue_vld, 0);
    ld_wb_vld = 1'b1; ld_wb_sel = 5'd7; step();
    ld_wb_vld = 1'b0;
    chk("t6_wb_edge", issue_vld, 0);
    step();
    chk("t6_membuf", issue_vld, 0);
    membuf_empty = 1'b1; step();
    chk("t6_issue", issue_vld, 1);

    // reset discards a pending scoreboard bit
    idle(2);
    drive(1'b1, lw(3, 0), 32'h700); step();
    drive(1'b1, add(4, 3, 0), 32'h704); step();
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t7_stall", issue_vld, 0);
    rst = 1'b0; #1;
    chk("t7_rst_vld", issue_vld, 0);
    chk("t7_rst_rdy", fetch_rdy, 1);
    step();
    rst = 1'b1; step();
    drive(1'b1, add(4, 3, 0), 32'h708); step();
    drive(1'b0, 32'd0, 32'd0); step();
    chk("t7_issue", issue_vld, 1);

    idle(3);
    chk("drain", exp_instr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
In-order issue scheduler that feeds the single-issue ALU/jump datapath. Fetched (instr, pc) pairs are buffered in a small FIFO. Each cycle the scheduler issues at most one instruction into a registered execute slot that drives the ALU's instr/pc inputs, stalling on load-use/WAW hazards, membuf back-pressure and SYSTEM/FENCE serialization. A taken jump reported by the ALU flushes all younger work.

Parameters:
XLEN, 32, datapath width for instr and pc.
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous active-low reset
fetch_vld  in  1  fetch offers instr/pc
fetch_instr  in  XLEN  fetched instruction
fetch_pc  in  XLEN  its pc
fetch_rdy  out  1  FIFO can accept; transfer occurs when fetch_vld & fetch_rdy
issue_instr  out  XLEN  to ALU instr; 0 when the slot is empty (decodes as a bubble)
issue_pc  out  XLEN  to ALU pc; 0 when the slot is empty
issue_vld  out  1  execute slot holds a live instruction
jump_vld  in  1  ALU taken jump for the instruction in the execute slot
mem_rdy  in  1  membuf can accept one request next cycle
membuf_empty  in  1  no outstanding memory operations
ld_wb_vld  in  1  load data written back to the register file
ld_wb_sel  in  5  destination register of that writeback

Behaviour:
- Reset (rst=0, asynchronous): FIFO count=0, read/write pointers=0, 32-bit scoreboard=0, issue_vld=0, issue_instr=0, issue_pc=0. fetch_rdy=1 (count<DEPTH).
- FIFO: fetch_rdy = (count != DEPTH), computed from the registered count with no same-cycle pop bypass, so a full FIFO refuses a push even in a cycle when it pops. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- Head decode (only when instr[1:0]==2'b11), by opcode instr[6:2]:
  - rs0 = instr[19:15] for JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and CSRR with instr[14]=0.
  - rs1 = instr[24:20] for BRANCH, STORE, OP.
  - rd = instr[11:7] for LUI, AUIPC, JAL, JALR, OP_IMM, OP, CSRR.
  - is_load = opcode 00000. is_mem = opcode 00000 or 01000. is_sys = opcode 11100 or 00011, and every undefined opcode.
  - Register 0 never causes a hazard.
- busy(r) = scoreboard[r] | (issue_vld & slot_is_load & slot_rd==r).
- Stall the head if any of:
  - busy(rs0) or busy(rs1) (RAW);
  - busy(rd) (WAW);
  - is_mem & !mem_rdy;
  - is_sys & (!membuf_empty | scoreboard!=0 | (issue_vld & slot_is_load)).
- Issue: when count>0, no stall and jump_vld=0, pop the head into the execute slot (issue_vld=1 next cycle). Otherwise load the slot with a bubble (issue_vld=0, instr=0, pc=0). The execute slot holds each instruction for exactly one cycle. Throughput is 1 instruction per cycle with no hazards. Latency from fetch accept to issue_vld is 2 cycles when the FIFO is empty.
- Scoreboard set: at the clock edge ending a cycle where the slot holds a load with rd!=0, set scoreboard[rd]. Loads never assert jump_vld, so they always commit.
- Scoreboard clear: ld_wb_vld clears bit ld_wb_sel. Set and clear are applied in the same edge with set winning; WAW stalling makes a same-register collision impossible in legal operation.
- Flush on jump_vld=1:
  - next cycle: FIFO count=0, pointers=0, slot=bubble;
  - a fetch accepted in the same cycle is discarded;
  - scoreboard unaffected (older loads still complete).
- Asserting rst mid-operation discards all state, including pending scoreboard bits. Writebacks arriving after reset are ignored harmlessly (clearing an already-clear bit).

Test Plan:
- Reset then stream 4 ADDIs back-to-back with fetch_vld=1 -> fetch_rdy=1 throughout; issue_vld rises 2 cycles after the first accept, then issue_instr follows in order one per cycle.
- LW x5 then ADD x6,x5,x1 -> ADD is held with issue_vld=0 until ld_wb_vld=1 with ld_wb_sel=5; it issues the following cycle and scoreboard[5]=0.
- Hold the execute slot stalled and push 5 instrs -> fetch_rdy=0 once count=4; the 5th is accepted only after a pop; order is preserved across the pointer wrap.
- Slot holds BEQ with jump_vld=1 while 3 instrs are queued and fetch pushes a 4th -> next cycle count=0 and issue_vld=0; the next accepted instr issues normally.
- SW with mem_rdy=0 for 3 cycles -> no issue during those cycles; issues the cycle after mem_rdy=1.
- ECALL behind an outstanding LW x7 with membuf_empty=0 -> ECALL is held until writeback of x7 and membuf_empty=1, then issues.
